hankel_stream_gen: RTL and testbench
====================================

// Module: hankel_stream_gen
// PURPOSE
//  Parametrised Hankel/Toeplitz matrix generator. On start, reads a 1-D sequence from
//  sync-read memory via addr/rd and streams the ROWS x COLS matrix row-major on a
//  valid/ready output with (row,col) tags. Sits between sample memory and matrix cores.
// PARAMETERS
//  DW    16  data width of memory word and output element
//  AW    8   memory address width; address arithmetic is modulo 2^AW
//  ROWS  8   matrix rows (>=1)
//  COLS  8   matrix columns (>=1); sequence length read = ROWS+COLS-1
//  RW/CW     localparams: $clog2 of ROWS/COLS, minimum 1
// PORTS
//  clk        in   1    clock, all logic on posedge
//  rst        in   1    synchronous, active-high reset
//  start      in   1    1-cycle request; accepted only in IDLE
//  mode       in   1    0 = Hankel H[i][j]=x[i+j]; 1 = Toeplitz T[i][j]=x[COLS-1+i-j]
//  base_addr  in   AW   address of x[0]; latched with mode on accepted start
//  data       in   DW   memory read data, valid the cycle after rd=1
//  addr       out  AW   memory read address
//  rd         out  1    memory read strobe
//  out_data   out  DW   matrix element
//  out_row    out  RW   row index of out_data
//  out_col    out  CW   column index of out_data
//  out_valid  out  1    out_data/out_row/out_col valid
//  out_ready  in   1    consumer accepts when out_valid && out_ready
//  busy       out  1    high in every state except IDLE
//  done       out  1    1-cycle pulse after last element accepted
// BEHAVIOUR
//  Reset: state=IDLE; addr, rd, out_data, out_row, out_col, out_valid, busy, done = 0.
//  States: IDLE -> FETCH -> LATCH -> SEND -> (FETCH | DONE) -> IDLE.
//  IDLE : start=1 latches base_addr/mode, clears i,j -> FETCH. start ignored elsewhere.
//  FETCH: rd=1 for exactly 1 cycle, addr = base+i+j (mode 0) or base+COLS-1+i-j (mode 1),
//         truncated to AW bits (wrap past 2^AW-1 to 0). -> LATCH.
//  LATCH: rd=0; register data into out_data, i->out_row, j->out_col; out_valid=1 next cycle.
//  SEND : hold out_* stable while out_ready=0; no rd issued. On out_valid&&out_ready:
//         out_valid=0 next cycle; if (i,j)==(ROWS-1,COLS-1) -> DONE, else
//         j++ (j wraps to 0 with i++) -> FETCH.
//  DONE : done=1 for this cycle only, busy=1 -> IDLE (busy=0 next cycle).
//  Latency: start accepted edge -> rd in next cycle; first out_valid 3 cycles after start
//  accepted; 3 cycles/element with out_ready tied 1; ROWS*COLS elements, each exactly once.
//  rd is never asserted outside FETCH; one rd per element (no reuse of prior reads).
//  ROWS=1 or COLS=1 legal: single row/column streamed, done after ROWS*COLS accepts.
//  start coincident with DONE or rst: ignored. rst mid-operation: abort, all outputs to
//  reset values next cycle, in-flight element discarded, no done pulse.
//  mode/base_addr changes after start have no effect until next accepted start.
// TESTING
//  T1 reset: rst=1 2 cycles mid-run -> all outputs 0, state IDLE, no rd until new start.
//  T2 Hankel ROWS=COLS=4, base 0, mem[a]=a, out_ready=1 -> 16 outputs 0,1,2,3,1,2,3,4,
//     2,3,4,5,3,4,5,6 with row/col tags 0..3; 3 cycles/element; done 1 pulse; 16 rd total.
//  T3 Toeplitz 3x3, base 0x10, mem[a]=a -> rows {12,11,10},{13,12,11},{14,13,12} (hex).
//  T4 backpressure: out_ready=0 for 5 cycles on element (1,2) -> out_* stable, rd=0,
//     then single accept; total stream identical to T2.
//  T5 wrap: Hankel 4x4, base 0xFE -> first row addrs FE,FF,00,01; last element addr 04.
//  T6 start pulsed while busy and during DONE -> ignored; exactly one done per run.

Source files
------------

// File: rtl/hankel_stream_gen.sv
// hankel_stream_gen
//   Reads a 1-D sample sequence x[] from a synchronous-read memory and streams the
//   ROWS x COLS Hankel (H[i][j] = x[i+j]) or Toeplitz (T[i][j] = x[COLS-1+i-j]) matrix
//   in row-major order on a valid/ready port, each element tagged with its (row, col).
//   Every element costs one memory read; nothing is cached between elements.
// Ports
//   clk, rst          clock and synchronous active-high reset
//   start             one-cycle request, honoured only when idle
//   mode              0 = Hankel, 1 = Toeplitz (latched on accepted start)
//   base_addr         address of x[0] (latched on accepted start)
//   data              memory read data, valid the cycle after rd
//   addr, rd          memory read address and strobe
//   out_data          matrix element
//   out_row, out_col  element indices
//   out_valid         element valid; consumed when out_valid && out_ready
//   out_ready         consumer ready
//   busy              high whenever a matrix is in progress (including the done cycle)
//   done              one-cycle pulse after the final element is accepted
module hankel_stream_gen #(
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 8,
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8,
    localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] base_addr,
    input  logic [DW-1:0] data,
    output logic [AW-1:0] addr,
    output logic          rd,
    output logic [DW-1:0] out_data,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {StIdle, StFetch, StLatch, StSend, StDone} state_t;

    state_t        state_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic          mode_q;
    logic [AW-1:0] base_q;

    logic [RW-1:0] next_row;
    logic [CW-1:0] next_col;
    logic          last_elem;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] next_addr;

    // Sequence address of element (r, c); all arithmetic wraps modulo 2^AW.
    function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] b, input logic m,
                                              input logic [RW-1:0] r, input logic [CW-1:0] c);
        logic [AW-1:0] ra;
        logic [AW-1:0] ca;
        ra = AW'(r);
        ca = AW'(c);
        if (m) begin
            return b + AW'(COLS - 1) + ra - ca;
        end
        return b + ra + ca;
    endfunction

    always_comb begin
        next_row  = row_q;
        next_col  = col_q + CW'(1);
        if (col_q == CW'(COLS - 1)) begin
            next_col = '0;
            next_row = row_q + RW'(1);
        end
        last_elem  = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
        // First address uses the live inputs since they are latched on the same edge.
        first_addr = addr_of(base_addr, mode, '0, '0);
        next_addr  = addr_of(base_q, mode_q, next_row, next_col);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            row_q     <= '0;
            col_q     <= '0;
            mode_q    <= 1'b0;
            base_q    <= '0;
            addr      <= '0;
            rd        <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // rd and done are single-cycle strobes unless re-armed below.
            rd   <= 1'b0;
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q  <= base_addr;
                        mode_q  <= mode;
                        row_q   <= '0;
                        col_q   <= '0;
                        addr    <= first_addr;
                        rd      <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    state_q <= StLatch;
                end
                StLatch: begin
                    out_data  <= data;
                    out_row   <= row_q;
                    out_col   <= col_q;
                    out_valid <= 1'b1;
                    state_q   <= StSend;
                end
                StSend: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_elem) begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            row_q   <= next_row;
                            col_q   <= next_col;
                            addr    <= next_addr;
                            rd      <= 1'b1;
                            state_q <= StFetch;
                        end
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hankel_stream_gen.sv
module tb_hankel_stream_gen;

    logic        clk = 1'b0;
    logic        rst;

    // 4x4 instance
    logic        start4, mode4, ready4;
    logic [7:0]  base4;
    logic [15:0] data4;
    logic [7:0]  addr4;
    logic        rd4;
    logic [15:0] out_data4;
    logic [1:0]  out_row4, out_col4;
    logic        out_valid4, busy4, done4;

    // 3x3 instance
    logic        start3, mode3, ready3;
    logic [7:0]  base3;
    logic [15:0] data3;
    logic [7:0]  addr3;
    logic        rd3;
    logic [15:0] out_data3;
    logic [1:0]  out_row3, out_col3;
    logic        out_valid3, busy3, done3;

    int total = 0;
    int bad   = 0;

    int q_data4[$], q_row4[$], q_col4[$];
    int q_data3[$], q_row3[$], q_col3[$];
    int rd_cnt4 = 0, done_cnt4 = 0, rd_cnt3 = 0, done_cnt3 = 0;

    always #5 clk = ~clk;

    hankel_stream_gen #(.DW(16), .AW(8), .ROWS(4), .COLS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .base_addr(base4),
        .data(data4), .addr(addr4), .rd(rd4), .out_data(out_data4), .out_row(out_row4),
        .out_col(out_col4), .out_valid(out_valid4), .out_ready(ready4), .busy(busy4),
        .done(done4)
    );

    hankel_stream_gen #(.DW(16), .AW(8), .ROWS(3), .COLS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode3), .base_addr(base3),
        .data(data3), .addr(addr3), .rd(rd3), .out_data(out_data3), .out_row(out_row3),
        .out_col(out_col3), .out_valid(out_valid3), .out_ready(ready3), .busy(busy3),
        .done(done3)
    );

    // Memory model: mem[a] = a, synchronous read.
    always @(posedge clk) begin
        if (rd4) data4 <= {8'h00, addr4};
        if (rd3) data3 <= {8'h00, addr3};
    end

    // Stream and strobe recorders.
    always @(posedge clk) begin
        if (!rst) begin
            if (out_valid4 && ready4) begin
                q_data4.push_back(int'(out_data4));
                q_row4.push_back(int'(out_row4));
                q_col4.push_back(int'(out_col4));
            end
            if (out_valid3 && ready3) begin
                q_data3.push_back(int'(out_data3));
                q_row3.push_back(int'(out_row3));
                q_col3.push_back(int'(out_col3));
            end
            if (rd4) rd_cnt4++;
            if (done4) done_cnt4++;
            if (rd3) rd_cnt3++;
            if (done3) done_cnt3++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ea(input logic [7:0] b, input logic m, input int i,
                                      input int j, input int cols);
        if (m) return 8'(int'(b) + cols - 1 + i - j);
        return 8'(int'(b) + i + j);
    endfunction

    task automatic chk_idle4(input string tag);
        chk({tag, ".addr"}, 32'(addr4), 0);
        chk({tag, ".rd"}, 32'(rd4), 0);
        chk({tag, ".data"}, 32'(out_data4), 0);
        chk({tag, ".row"}, 32'(out_row4), 0);
        chk({tag, ".col"}, 32'(out_col4), 0);
        chk({tag, ".valid"}, 32'(out_valid4), 0);
        chk({tag, ".busy"}, 32'(busy4), 0);
        chk({tag, ".done"}, 32'(done4), 0);
    endtask

    // One full 4x4 run on dut4, optionally stalling on (1,2) and poking start while busy.
    task automatic run4(input logic m, input logic [7:0] b, input bit stall, input bit poke,
                        input string tag);
        int q0, r0, d0, cnt, k;
        bit seen_done, stalled;
        logic [15:0] sd;
        q0 = q_data4.size();
        r0 = rd_cnt4;
        d0 = done_cnt4;
        seen_done = 0;
        stalled = 0;
        @(negedge clk);
        start4 = 1'b1; mode4 = m; base4 = b;
        @(negedge clk);
        start4 = 1'b0;
        cnt = 1;
        chk({tag, ".first_rd"}, 32'(rd4), 1);
        chk({tag, ".first_addr"}, 32'(addr4), 32'(ea(b, m, 0, 0, 4)));
        chk({tag, ".busy"}, 32'(busy4), 1);
        // Inputs altered after start must not matter.
        mode4 = ~m; base4 = 8'h55;
        @(negedge clk);
        cnt = 2;
        chk({tag, ".latch_rd"}, 32'(rd4), 0);
        chk({tag, ".latch_valid"}, 32'(out_valid4), 0);
        @(negedge clk);
        cnt = 3;
        chk({tag, ".first_valid"}, 32'(out_valid4), 1);
        chk({tag, ".first_data"}, 32'(out_data4), 32'(ea(b, m, 0, 0, 4)));
        while (cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (poke) start4 = (cnt == 10);
            if (stall && !stalled && out_valid4 && out_row4 == 2'd1 && out_col4 == 2'd2) begin
                stalled = 1;
                ready4 = 1'b0;
                sd = out_data4;
                repeat (5) begin
                    @(negedge clk);
                    cnt++;
                    chk({tag, ".stall_valid"}, 32'(out_valid4), 1);
                    chk({tag, ".stall_data"}, 32'(out_data4), 32'(sd));
                    chk({tag, ".stall_tag"}, {28'd0, out_row4, out_col4}, 32'h6);
                    chk({tag, ".stall_rd"}, 32'(rd4), 0);
                end
                ready4 = 1'b1;
            end
            if (done4) begin
                seen_done = 1;
                break;
            end
        end
        chk({tag, ".done_seen"}, 32'(seen_done), 1);
        chk({tag, ".done_cycle"}, 32'(cnt), stall ? 54 : 49);
        chk({tag, ".done_busy"}, 32'(busy4), 1);
        if (poke) begin
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            chk({tag, ".after_done"}, 32'(done4), 0);
            chk({tag, ".after_busy"}, 32'(busy4), 0);
            repeat (3) begin
                @(negedge clk);
                chk({tag, ".ignored_rd"}, 32'(rd4), 0);
                chk({tag, ".ignored_busy"}, 32'(busy4), 0);
            end
        end else begin
            @(negedge clk);
            chk({tag, ".after_done"}, 32'(done4), 0);
            chk({tag, ".after_busy"}, 32'(busy4), 0);
        end
        chk({tag, ".count"}, 32'(q_data4.size() - q0), 16);
        chk({tag, ".rd_total"}, 32'(rd_cnt4 - r0), 16);
        chk({tag, ".done_total"}, 32'(done_cnt4 - d0), 1);
        if (q_data4.size() - q0 == 16) begin
            for (k = 0; k < 16; k++) begin
                chk($sformatf("%s.data%0d", tag, k), 32'(q_data4[q0+k]),
                    32'(ea(b, m, k / 4, k % 4, 4)));
                chk($sformatf("%s.row%0d", tag, k), 32'(q_row4[q0+k]), 32'(k / 4));
                chk($sformatf("%s.col%0d", tag, k), 32'(q_col4[q0+k]), 32'(k % 4));
            end
        end
    endtask

    initial begin
        int q0, r0, d0, cnt;
        bit seen_done;
        rst = 1'b1;
        start4 = 1'b0; mode4 = 1'b0; base4 = 8'h00; ready4 = 1'b1;
        start3 = 1'b0; mode3 = 1'b0; base3 = 8'h00; ready3 = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle4("reset");
        chk("reset3.busy", 32'(busy3), 0);
        chk("reset3.rd", 32'(rd3), 0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle4("idle");

        // Hankel 4x4, base 0.
        run4(1'b0, 8'h00, 1'b0, 1'b0, "hankel");

        // Backpressure on (1,2).
        run4(1'b0, 8'h00, 1'b1, 1'b0, "stall");

        // Reset mid-run.
        @(negedge clk);
        start4 = 1'b1; mode4 = 1'b0; base4 = 8'h20;
        @(negedge clk);
        start4 = 1'b0;
        repeat (7) @(negedge clk);
        chk("midrun.busy", 32'(busy4), 1);
        rst = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        chk_idle4("rst1");
        @(negedge clk);
        chk_idle4("rst2");
        rst = 1'b0;
        start4 = 1'b0;
        r0 = rd_cnt4;
        d0 = done_cnt4;
        repeat (10) @(negedge clk);
        chk("postrst.rd_cnt", 32'(rd_cnt4), 32'(r0));
        chk("postrst.done_cnt", 32'(done_cnt4), 32'(d0));
        chk_idle4("postrst");

        // Address wrap: base 0xFE.
        run4(1'b0, 8'hFE, 1'b0, 1'b0, "wrap");

        // Start pulses while busy and during the done cycle.
        run4(1'b0, 8'h40, 1'b0, 1'b1, "poke");

        // Toeplitz 3x3, base 0x10.
        q0 = q_data3.size();
        r0 = rd_cnt3;
        d0 = done_cnt3;
        seen_done = 0;
        @(negedge clk);
        start3 = 1'b1; mode3 = 1'b1; base3 = 8'h10;
        @(negedge clk);
        start3 = 1'b0; mode3 = 1'b0; base3 = 8'h80;
        cnt = 1;
        chk("toep.first_addr", 32'(addr3), 32'h12);
        while (cnt < 300) begin
            @(negedge clk);
            cnt++;
            if (done3) begin
                seen_done = 1;
                break;
            end
        end
        chk("toep.done_seen", 32'(seen_done), 1);
        chk("toep.done_cycle", 32'(cnt), 28);
        @(negedge clk);
        chk("toep.after_busy", 32'(busy3), 0);
        chk("toep.count", 32'(q_data3.size() - q0), 9);
        chk("toep.rd_total", 32'(rd_cnt3 - r0), 9);
        chk("toep.done_total", 32'(done_cnt3 - d0), 1);
        if (q_data3.size() - q0 == 9) begin
            for (int k = 0; k < 9; k++) begin
                chk($sformatf("toep.data%0d", k), 32'(q_data3[q0+k]),
                    32'(ea(8'h10, 1'b1, k / 3, k % 3, 3)));
                chk($sformatf("toep.row%0d", k), 32'(q_row3[q0+k]), 32'(k / 3));
                chk($sformatf("toep.col%0d", k), 32'(q_col3[q0+k]), 32'(k % 3));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
